// File: rtl/chdr_arb_pkg.sv
// rtl/chdr_arb_pkg.sv - shared types, header field positions and helpers for the CHDR packet arbiter
package chdr_arb_pkg;

    typedef enum logic [1:0] {
        DATA = 2'd0,
        FC   = 2'd1,
        CMD  = 2'd2,
        RESP = 2'd3
    } pkt_type_e;

    typedef enum logic {
        IDLE = 1'b0,
        PASS = 1'b1
    } state_e;

    localparam int PKT_TYPE_MSB = 63;
    localparam int HAS_TIME_BIT = 61;
    localparam int LEN_MSB      = 47;
    localparam int LEN_LSB      = 32;

    // Header length is in bytes; a trailing partial word still occupies a full word.
    function automatic logic [15:0] ceil_words(input logic [15:0] length);
        logic [16:0] sum;
        sum = {1'b0, length} + 17'd7;
        return 16'(sum >> 3);
    endfunction

endpackage

// File: rtl/chdr_arb_out_reg.sv
// rtl/chdr_arb_out_reg.sv - two-entry skid buffer; ready toward the arbiter is purely registered
module chdr_arb_out_reg #(
    parameter int DW = 67
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] in_tdata_i,
    input  logic          in_tvalid_i,
    output logic          in_tready_o,
    output logic [DW-1:0] out_tdata_o,
    output logic          out_tvalid_o,
    input  logic          out_tready_i
);

    logic [DW-1:0] main_q, main_d, skid_q, skid_d;
    logic          main_v_q, main_v_d, skid_v_q, skid_v_d;
    logic          in_fire;

    assign in_tready_o  = ~skid_v_q;
    assign in_fire      = in_tvalid_i & ~skid_v_q;
    assign out_tdata_o  = main_q;
    assign out_tvalid_o = main_v_q;

    always_comb begin
        main_d   = main_q;
        main_v_d = main_v_q;
        skid_d   = skid_q;
        skid_v_d = skid_v_q;
        if (!main_v_q || out_tready_i) begin
            if (skid_v_q) begin
                main_d   = skid_q;
                main_v_d = 1'b1;
                skid_v_d = 1'b0;
            end else begin
                main_v_d = in_fire;
                if (in_fire) main_d = in_tdata_i;
            end
        end else if (in_fire) begin
            // Output stalled: park the word so the input side keeps streaming for one more beat.
            skid_d   = in_tdata_i;
            skid_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q   <= '0;
            main_v_q <= 1'b0;
            skid_q   <= '0;
            skid_v_q <= 1'b0;
        end else begin
            main_q   <= main_d;
            main_v_q <= main_v_d;
            skid_q   <= skid_d;
            skid_v_q <= skid_v_d;
        end
    end

endmodule

// File: rtl/chdr_pkt_arbiter.sv
// rtl/chdr_pkt_arbiter.sv - packet-locked round-robin CHDR arbiter with control-class priority and length check
module chdr_pkt_arbiter
    import chdr_arb_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int WIDTH      = 64,
    parameter int PRIO_CTRL  = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_INPUTS*WIDTH-1:0]   i_tdata,
    input  logic [NUM_INPUTS-1:0]         i_tlast,
    input  logic [NUM_INPUTS-1:0]         i_tvalid,
    output logic [NUM_INPUTS-1:0]         i_tready,
    output logic [WIDTH-1:0]              o_tdata,
    output logic                          o_tlast,
    output logic                          o_tvalid,
    input  logic                          o_tready,
    output logic [$clog2(NUM_INPUTS)-1:0] o_src,
    output logic                          busy,
    output logic                          len_err
);

    localparam int SW = $clog2(NUM_INPUTS);
    localparam int PW = WIDTH + SW + 1;

    state_e                  state_q, state_d;
    logic [SW-1:0]           grant_q, grant_d, rr_q, rr_d, enc, win;
    logic [SW:0]             win_sum, win_wrap;
    logic [15:0]             cnt_q, cnt_d, len_q, len_d, cnt_inc, len_cur;
    logic                    len_err_q, len_err_d;
    logic [NUM_INPUTS-1:0]   ctrl, cand, rot;
    logic [2*NUM_INPUTS-1:0] dbl;
    logic [WIDTH-1:0]        g_tdata;
    logic                    g_tvalid, g_tlast, sk_ready, xfer;
    pkt_type_e               ptype;

    // Rotate candidates so rr_q sits at bit 0, take the lowest set bit, rotate the index back.
    always_comb begin
        ctrl = '0;
        ptype = DATA;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            ptype   = pkt_type_e'(i_tdata[WIDTH*k+PKT_TYPE_MSB -: 2]);
            ctrl[k] = (ptype == CMD) || (ptype == RESP);
        end
        cand = i_tvalid;
        if (PRIO_CTRL != 0 && |(i_tvalid & ctrl)) cand = i_tvalid & ctrl;
        dbl = {cand, cand} >> rr_q;
        rot = dbl[NUM_INPUTS-1:0];
        enc = '0;
        for (int i = NUM_INPUTS-1; i >= 0; i--) begin
            if (rot[i]) enc = SW'(i);
        end
        win_sum  = {1'b0, rr_q} + {1'b0, enc};
        win_wrap = win_sum - (SW+1)'(NUM_INPUTS);
        win      = (win_sum >= (SW+1)'(NUM_INPUTS)) ? win_wrap[SW-1:0] : win_sum[SW-1:0];
    end

    assign g_tdata  = i_tdata[WIDTH*grant_q +: WIDTH];
    assign g_tvalid = i_tvalid[grant_q];
    assign g_tlast  = i_tlast[grant_q];
    assign xfer     = (state_q == PASS) && g_tvalid && sk_ready;
    assign cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign len_cur  = (cnt_q == 16'd0) ? g_tdata[LEN_MSB:LEN_LSB] : len_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|cand) state_d = PASS;
            PASS:    if (xfer && g_tlast) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        i_tready = '0;
        busy     = (state_q == PASS);
        if (state_q == PASS) i_tready[grant_q] = sk_ready;
    end

    always_comb begin
        grant_d   = grant_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        len_err_d = 1'b0;
        if (state_q == IDLE && |cand) grant_d = win;
        if (xfer) begin
            if (cnt_q == 16'd0) len_d = g_tdata[LEN_MSB:LEN_LSB];
            if (g_tlast) begin
                cnt_d     = '0;
                rr_d      = (grant_q == SW'(NUM_INPUTS-1)) ? '0 : grant_q + SW'(1);
                len_err_d = (cnt_inc != ceil_words(len_cur));
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_q   <= '0;
            rr_q      <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            len_err_q <= 1'b0;
        end else begin
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            len_err_q <= len_err_d;
        end
    end

    assign len_err = len_err_q;

    chdr_arb_out_reg #(.DW(PW)) u_out_reg (
        .clk          (clk),
        .reset        (reset),
        .in_tdata_i   ({g_tlast, grant_q, g_tdata}),
        .in_tvalid_i  ((state_q == PASS) && g_tvalid),
        .in_tready_o  (sk_ready),
        .out_tdata_o  ({o_tlast, o_src, o_tdata}),
        .out_tvalid_o (o_tvalid),
        .out_tready_i (o_tready)
    );

endmodule

// File: tb/tb_chdr_pkt_arbiter.sv
// tb/tb_chdr_pkt_arbiter.sv - directed self-checking bench for chdr_pkt_arbiter
module tb_chdr_pkt_arbiter;
    import chdr_arb_pkg::*;

    localparam int NI = 4;
    localparam int W  = 64;

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic [1:0]  src;
        int          cyc;
    } cap_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NI*W-1:0] i_tdata = '0;
    logic [NI-1:0]   i_tlast = '0;
    logic [NI-1:0]   i_tvalid = '0;
    logic [NI-1:0]   i_tready;
    logic [W-1:0]    o_tdata;
    logic            o_tlast, o_tvalid;
    logic            o_tready = 1'b1;
    logic [1:0]      o_src;
    logic            busy, len_err;

    logic [64:0]     srcq [NI][$];
    cap_t            cap[$];
    int              errq[$];
    int              n_checks = 0;
    int              n_pass = 0;
    int              cyc = 0;
    logic            rand_rdy = 1'b0;
    logic [NI-1:0]   fire;
    logic            prev_stall = 1'b0;
    logic [63:0]     prev_data;

    chdr_pkt_arbiter #(.NUM_INPUTS(NI), .WIDTH(W), .PRIO_CTRL(1)) dut (
        .clk      (clk),
        .reset    (reset),
        .i_tdata  (i_tdata),
        .i_tlast  (i_tlast),
        .i_tvalid (i_tvalid),
        .i_tready (i_tready),
        .o_tdata  (o_tdata),
        .o_tlast  (o_tlast),
        .o_tvalid (o_tvalid),
        .o_tready (o_tready),
        .o_src    (o_src),
        .busy     (busy),
        .len_err  (len_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [63:0] pkt_word(input bit ctrl, input int len, input logic [15:0] tag, input int i);
        logic [63:0] w;
        if (i == 0) begin
            w = '0;
            w[PKT_TYPE_MSB -: 2]  = ctrl ? CMD : DATA;
            w[HAS_TIME_BIT]       = 1'b0;
            w[LEN_MSB:LEN_LSB]    = 16'(len);
            w[15:0]               = tag;
        end else begin
            w = {16'h0, tag, 32'(i)};
        end
        return w;
    endfunction

    task automatic push_pkt(input int k, input bit ctrl, input int len, input int nw, input logic [15:0] tag);
        for (int i = 0; i < nw; i++) srcq[k].push_back({(i == nw-1), pkt_word(ctrl, len, tag, i)});
    endtask

    task automatic chk_pkt(input int base, input int src, input bit ctrl, input int len, input int nw, input logic [15:0] tag);
        if (cap.size() < base + nw) begin
            check("pkt_missing", 64'(cap.size()), 64'(base + nw));
            return;
        end
        for (int i = 0; i < nw; i++) begin
            check("data", cap[base+i].data, pkt_word(ctrl, len, tag, i));
            check("src", 64'(cap[base+i].src), 64'(src));
            check("last", 64'(cap[base+i].last), 64'(i == nw-1));
        end
    endtask

    task automatic wait_cap(input int n, input int budget);
        int t = 0;
        while (cap.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check("word_count", 64'(cap.size()), 64'(n));
    endtask

    task automatic clear_all();
        for (int k = 0; k < NI; k++) srcq[k].delete();
        cap.delete();
        errq.delete();
        i_tvalid = '0;
        i_tlast  = '0;
        i_tdata  = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_all();
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        cap.delete();
        errq.delete();
    endtask

    // Drive sources at negedge, sample handshakes 1ns later, retire accepted words after posedge.
    always begin
        @(negedge clk);
        cyc++;
        for (int k = 0; k < NI; k++) begin
            if (srcq[k].size() > 0) begin
                i_tvalid[k]         = 1'b1;
                i_tdata[k*W +: W]   = srcq[k][0][63:0];
                i_tlast[k]          = srcq[k][0][64];
            end else begin
                i_tvalid[k]         = 1'b0;
                i_tdata[k*W +: W]   = '0;
                i_tlast[k]          = 1'b0;
            end
        end
        o_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (prev_stall) begin
            check("hold_valid", 64'(o_tvalid), 64'd1);
            check("hold_data", o_tdata, prev_data);
        end
        prev_stall = o_tvalid & ~o_tready;
        prev_data  = o_tdata;
        if (o_tvalid && o_tready) cap.push_back('{data: o_tdata, last: o_tlast, src: o_src, cyc: cyc});
        if (len_err) errq.push_back(cyc);
        fire = i_tvalid & i_tready;
        @(posedge clk);
        for (int k = 0; k < NI; k++) begin
            if (fire[k] && srcq[k].size() > 0) void'(srcq[k].pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        repeat (3) @(negedge clk);
        #1;
        check("rst_tvalid", 64'(o_tvalid), 64'd0);
        check("rst_tlast", 64'(o_tlast), 64'd0);
        check("rst_tdata", o_tdata, 64'd0);
        check("rst_src", 64'(o_src), 64'd0);
        check("rst_tready", 64'(i_tready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_len_err", 64'(len_err), 64'd0);
        @(negedge clk);
        #2 reset = 1'b0;

        // Two DATA packets of 5 words, lowest index wins first, one idle cycle between them.
        @(negedge clk);
        #2;
        push_pkt(0, 0, 40, 5, 16'h0010);
        push_pkt(2, 0, 40, 5, 16'h0020);
        wait_cap(10, 60);
        chk_pkt(0, 0, 0, 40, 5, 16'h0010);
        chk_pkt(5, 2, 0, 40, 5, 16'h0020);
        if (cap.size() >= 6) check("pkt_gap", 64'(cap[5].cyc - cap[4].cyc), 64'd2);
        check("t1_len_err", 64'(errq.size()), 64'd0);

        // Round robin across four continuously requesting inputs.
        do_reset();
        for (int p = 0; p < 3; p++)
            for (int k = 0; k < NI; k++) push_pkt(k, 0, 16, 2, 16'(k*16 + p));
        wait_cap(24, 200);
        for (int j = 0; j < 12; j++) chk_pkt(2*j, j % 4, 0, 16, 2, 16'((j % 4)*16 + j/4));
        check("t2_len_err", 64'(errq.size()), 64'd0);

        // CMD header on input 3 beats DATA on input 1 despite rr_ptr = 0.
        do_reset();
        push_pkt(1, 0, 16, 2, 16'h0031);
        push_pkt(3, 1, 16, 2, 16'h0033);
        wait_cap(4, 40);
        chk_pkt(0, 3, 1, 16, 2, 16'h0033);
        chk_pkt(2, 1, 0, 16, 2, 16'h0031);

        // Length 32 over 3 words is short; length 28 over 4 words is accepted.
        clear_all();
        push_pkt(0, 0, 32, 3, 16'h0041);
        push_pkt(0, 0, 28, 4, 16'h0042);
        wait_cap(7, 60);
        chk_pkt(0, 0, 0, 32, 3, 16'h0041);
        chk_pkt(3, 0, 0, 28, 4, 16'h0042);
        check("t4_len_err_n", 64'(errq.size()), 64'd1);
        if (errq.size() >= 1 && cap.size() >= 3) check("t4_len_err_pkt", 64'(errq[0]), 64'(cap[2].cyc));

        // Random output backpressure over a 10-word ramp.
        clear_all();
        rand_rdy = 1'b1;
        push_pkt(2, 0, 80, 10, 16'h0000);
        wait_cap(10, 300);
        if (cap.size() >= 10)
            for (int i = 0; i < 10; i++) check("ramp", 64'(cap[i].data[31:0]), 64'(i));
        check("t5_len_err", 64'(errq.size()), 64'd0);
        rand_rdy = 1'b0;
        repeat (2) @(negedge clk);

        // Reset mid-packet on input 1, then rr_ptr must be back at 0.
        clear_all();
        push_pkt(1, 0, 48, 6, 16'h0061);
        t = 0;
        while (cap.size() < 2 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("t6_busy_before", 64'(busy), 64'd1);
        #3 reset = 1'b1;
        #1;
        check("t6_rst_tvalid", 64'(o_tvalid), 64'd0);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_tready", 64'(i_tready), 64'd0);
        @(negedge clk);
        #2;
        clear_all();
        reset = 1'b0;
        push_pkt(0, 0, 16, 2, 16'h0062);
        push_pkt(3, 0, 16, 2, 16'h0063);
        wait_cap(4, 40);
        chk_pkt(0, 0, 0, 16, 2, 16'h0062);
        chk_pkt(2, 3, 0, 16, 2, 16'h0063);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
